fp_align_addsub: RTL

- Pipelined front end of the FP32 adder/subtractor. Sits directly upstream of the normalise/round stage.
- Unpacks two IEEE-754 single-precision operands and orders them by exponent.
- Aligns the smaller operand with a sticky bit, then forms the signed 27-bit mantissa sum.
- Outputs result_mant, exp_result, result_sign and carry_out, which feed the normaliser combinationally. Uses a valid/ready handshake on both sides.

---
 rtl/fp_align_addsub.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/fp_align_addsub.sv
// FP32 add/sub front end: unpack and order operands, align the smaller one with sticky, form the signed 27-bit mantissa sum.
// Latency 3 cycles from input handshake to out_valid; throughput 1 pair/cycle.
// Backpressure: one global enable (~out_valid | out_ready) freezes all three stages; in_ready mirrors it.
//
// Ports: clk/rst (sync, active-high); in_valid/in_ready + a, b, op_sub on the input side;
//        out_valid/out_ready + result_mant (signed), exp_result, result_sign, carry_out on the output side.
module fp_align_addsub #(
  parameter int WIDTH  = 32,
  parameter int MANT_W = 27
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              op_sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] result_mant,
  output logic [7:0]        exp_result,
  output logic              result_sign,
  output logic              carry_out
);

  localparam logic [MANT_W-1:0] ONE = MANT_W'(1);

  typedef struct packed {
    logic [MANT_W-1:0] big_ext;
    logic              big_sign;
    logic [7:0]        big_exp;
    logic [MANT_W-1:0] small_ext;
    logic              small_sign;
    logic [7:0]        d;
  } s1_t;

  typedef struct packed {
    logic [MANT_W-1:0] big_ext;
    logic              big_sign;
    logic [7:0]        big_exp;
    logic [MANT_W-1:0] small_al;
    logic              small_sign;
  } s2_t;

  typedef struct packed {
    logic [MANT_W-1:0] mant;
    logic [7:0]        exp;
    logic              sign;
    logic              carry;
  } s3_t;

  logic adv;
  logic s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d, s3_vld_q, s3_vld_d;
  s1_t  s1_q, s1_d, s1_new;
  s2_t  s2_q, s2_d, s2_new;
  s3_t  s3_q, s3_d, s3_new;

  assign adv      = ~s3_vld_q | out_ready;
  assign in_ready = adv;

  // Stage 1: unpack and order by exponent. Denormals use exponent 1 with hidden bit 0.
  logic [7:0]        exp_a, exp_b;
  logic [MANT_W-1:0] ext_a, ext_b;
  logic              sign_a, sign_b;

  always_comb begin
    exp_a  = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
    exp_b  = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
    ext_a  = {2'b00, |a[30:23], a[22:0], 1'b0};
    ext_b  = {2'b00, |b[30:23], b[22:0], 1'b0};
    sign_a = a[31];
    sign_b = b[31] ^ op_sub;
    s1_new = '0;
    if (exp_a >= exp_b) begin
      s1_new.big_ext    = ext_a;
      s1_new.big_sign   = sign_a;
      s1_new.big_exp    = exp_a;
      s1_new.small_ext  = ext_b;
      s1_new.small_sign = sign_b;
      s1_new.d          = exp_a - exp_b;
    end else begin
      s1_new.big_ext    = ext_b;
      s1_new.big_sign   = sign_b;
      s1_new.big_exp    = exp_b;
      s1_new.small_ext  = ext_a;
      s1_new.small_sign = sign_a;
      s1_new.d          = exp_b - exp_a;
    end
  end

  // Stage 2: right-align the smaller operand; everything shifted out collapses into bit 0.
  logic [MANT_W-1:0] lost_mask, shifted;

  always_comb begin
    s2_new            = '0;
    s2_new.big_ext    = s1_q.big_ext;
    s2_new.big_sign   = s1_q.big_sign;
    s2_new.big_exp    = s1_q.big_exp;
    s2_new.small_sign = s1_q.small_sign;
    lost_mask         = (ONE << s1_q.d) - ONE;
    shifted           = s1_q.small_ext >> s1_q.d;
    if (s1_q.d < 8'd26) begin
      s2_new.small_al = {shifted[MANT_W-1:1],
                         shifted[0] | (|(s1_q.small_ext & lost_mask))};
    end else begin
      // Entire mantissa lies below the guard position: only the sticky survives.
      s2_new.small_al = {{(MANT_W-1){1'b0}}, |s1_q.small_ext};
    end
  end

  // Stage 3: signed add. Both magnitudes are below 2^25, so the sum never overflows 27 bits.
  logic [MANT_W-1:0] big_s, small_s, sum, mag;

  always_comb begin
    big_s        = s2_q.big_sign   ? (~s2_q.big_ext  + ONE) : s2_q.big_ext;
    small_s      = s2_q.small_sign ? (~s2_q.small_al + ONE) : s2_q.small_al;
    sum          = big_s + small_s;
    mag          = sum[MANT_W-1] ? (~sum + ONE) : sum;
    s3_new       = '0;
    s3_new.mant  = sum;
    s3_new.exp   = s2_q.big_exp;
    s3_new.sign  = sum[MANT_W-1];
    s3_new.carry = mag[MANT_W-2];
  end

  // Pipeline advance: data registers only load behind a valid bit to avoid needless toggling.
  always_comb begin
    s1_vld_d = s1_vld_q;
    s2_vld_d = s2_vld_q;
    s3_vld_d = s3_vld_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    s3_d     = s3_q;
    if (adv) begin
      s1_vld_d = in_valid;
      s2_vld_d = s1_vld_q;
      s3_vld_d = s2_vld_q;
      if (in_valid) s1_d = s1_new;
      if (s1_vld_q) s2_d = s2_new;
      if (s2_vld_q) s3_d = s3_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s3_vld_q <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      s3_vld_q <= s3_vld_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
    end
  end

  assign out_valid   = s3_vld_q;
  assign result_mant = s3_q.mant;
  assign exp_result  = s3_q.exp;
  assign result_sign = s3_q.sign;
  assign carry_out   = s3_q.carry;

endmodule
